// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit
// Contents: data/PC widths, reset PC and step, fetch FSM state enum,
// fetch buffer entry struct and a PC word-alignment helper.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_RESET = 32'h0;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef enum logic {RUN, DROP} fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory and decode-side signals of the fetch unit
// master (fetch unit): drives imem_req/imem_addr and ir/ir_pc/ir_valid,
//   receives imem_rdata/imem_ack, ir_ready and redirect/redirect_pc.
// slave (memory + decode/control): the mirror image.
interface instr_fetch_if #(parameter int IMEM_AW = 6);
    import fetch_pkg::*;
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    ir_pc;
    logic               ir_valid;
    logic               ir_ready;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;

    modport master (
        output imem_req, imem_addr, ir, ir_pc, ir_valid,
        input  imem_rdata, imem_ack, ir_ready, redirect, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, ir, ir_pc, ir_valid,
        output imem_rdata, imem_ack, ir_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: shift-register fetch buffer with a registered head entry
// Ports: clk, rst_n (async active-low); push/din write an entry, pop drops
// the head, flush empties the buffer and beats push; head is entry 0 and
// count is the current occupancy.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    fetch_entry_t mem [DEPTH];
    logic pop_ok, push_ok;
    logic [CW-1:0] wr_idx;

    assign pop_ok = pop && count != '0;
    assign push_ok = push && !flush && (count < CW'(DEPTH) || pop_ok);
    // Entries shift toward slot 0 on pop, so the write slot is one lower then.
    assign wr_idx = count - CW'(pop_ok);
    assign head = mem[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (push_ok && wr_idx == CW'(i)) mem[i] <= din;
                else if (pop_ok && i < DEPTH - 1) mem[i] <= mem[(i + 1) % DEPTH];
            count <= flush ? '0 : count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, single-outstanding imem reader and decode-side buffer
// Ports: clk, rst_n (async active-low); bus (instr_fetch_if.master) carries
// imem_req/imem_addr/imem_rdata/imem_ack, ir/ir_pc/ir_valid/ir_ready and
// redirect/redirect_pc. With INSTR_FETCH_PERF_EN defined, fetch_count
// reports saturating pops since reset.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int IMEM_AW = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_if.master     bus
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t state, state_nx;
    logic [PC_W-1:0] pc, pc_nx;
    logic req, req_nx, launch, ack, push, pop;
    logic [IMEM_AW-1:0] addr;
    logic [CW-1:0] count, count_nx;
    fetch_entry_t head, din;

    assign ack = req & bus.imem_ack;
    assign pop = bus.ir_valid & bus.ir_ready;
    // Returned data is only kept in RUN and when no redirect lands on the same edge.
    assign push = ack & (state == RUN) & ~bus.redirect;
    assign din = '{instr: bus.imem_rdata, pc: pc};

    always_comb begin
        pc_nx = bus.redirect ? align_pc(bus.redirect_pc) : push ? pc + PC_STEP : pc;
        state_nx = (state == RUN && bus.redirect && req && !bus.imem_ack) ? DROP :
                   (state == DROP && ack) ? RUN : state;
        count_nx = bus.redirect ? '0 : count + CW'(push) - CW'(pop);
        // Launch on the edge the previous request completes, giving back-to-back reads.
        launch = (!req || ack) && state_nx == RUN && count_nx < CW'(FIFO_DEPTH);
        req_nx = (req && !ack) || launch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc <= PC_RESET;
            req <= 1'b0;
            addr <= '0;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
            req <= req_nx;
            if (launch) addr <= pc_nx[IMEM_AW+1:2];
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .flush(bus.redirect),
        .din(din),
        .head(head),
        .count(count)
    );

    assign bus.imem_req = req;
    assign bus.imem_addr = addr;
    assign bus.ir = head.instr;
    assign bus.ir_pc = head.pc;
    assign bus.ir_valid = count != '0;

`ifdef INSTR_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_count <= '0;
        else if (pop && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a latency-configurable memory
module tb_instr_fetch;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if #(.IMEM_AW(6)) bus ();
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    instr_fetch #(.IMEM_AW(6), .FIFO_DEPTH(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;
    logic mem_en = 1'b0;
    int lat = 0;
    int mem_wait = 0;
    logic man_ack = 1'b0;
    logic [31:0] man_rdata = '0;
    fetch_entry_t exp_q[$];
    fetch_entry_t exp;

    function automatic logic [31:0] mem_word(input logic [5:0] w);
        return w == 6'd0 ? 32'h11 : w == 6'd1 ? 32'h22 : w == 6'd2 ? 32'h33 : 32'hA000_0000 | 32'(w);
    endfunction

    // Memory model: updates ack/rdata just after each falling edge.
    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                bus.imem_ack = 1'b0;
                mem_wait = 0;
            end else if (!mem_en) begin
                bus.imem_ack = man_ack;
                bus.imem_rdata = man_rdata;
                mem_wait = 0;
            end else if (bus.imem_req && mem_wait >= lat) begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
                mem_wait = 0;
            end else begin
                bus.imem_ack = 1'b0;
                mem_wait = bus.imem_req ? mem_wait + 1 : 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.ir_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        mem_en = 1'b0;
        man_ack = 1'b0;
        man_rdata = '0;
        lat = 0;
        bus.ir_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mem_en = 1'b0;
        bus.ir_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        n_checks++; if (bus.imem_addr !== 6'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", bus.imem_addr); end
        n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.ir_valid); end
        n_checks++; if ({bus.ir, bus.ir_pc} !== 64'h0) begin n_fail++; $display("FAIL reset_ir: got %h_%h expected 0_0", bus.ir, bus.ir_pc); end
`ifdef INSTR_FETCH_PERF_EN
        n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 6'h0}) begin n_fail++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_stream;
        apply_reset();
        bus.ir_ready = 1'b1;
        mem_en = 1'b1;
        exp_q.push_back('{instr: 32'h11, pc: 32'h0});
        exp_q.push_back('{instr: 32'h22, pc: 32'h4});
        exp_q.push_back('{instr: 32'h33, pc: 32'h8});
        @(negedge clk);
        n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid: got %b expected 0", bus.ir_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            n_checks++;
            if ({bus.ir_valid, bus.ir, bus.ir_pc} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL stream_%0d: got v=%b ir=%h pc=%h expected v=1 ir=%h pc=%h", k, bus.ir_valid, bus.ir, bus.ir_pc, exp.instr, exp.pc);
            end
        end
    endtask

    task automatic test_backpressure;
        bit got;
        apply_reset();
        lat = 3;
        mem_en = 1'b1;
        exp_q.push_back('{instr: 32'h11, pc: 32'h0});
        exp_q.push_back('{instr: 32'h22, pc: 32'h4});
        exp_q.push_back('{instr: 32'h33, pc: 32'h8});
        repeat (16) @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req: got %b expected 0", bus.imem_req); end
        exp = exp_q.pop_front();
        n_checks++; if ({bus.ir_valid, bus.ir, bus.ir_pc} !== {1'b1, exp}) begin n_fail++; $display("FAIL bp_head0: got v=%b ir=%h pc=%h expected v=1 ir=%h pc=%h", bus.ir_valid, bus.ir, bus.ir_pc, exp.instr, exp.pc); end
        bus.ir_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 6'h2}) begin n_fail++; $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=02", bus.imem_req, bus.imem_addr); end
        exp = exp_q.pop_front();
        n_checks++; if ({bus.ir_valid, bus.ir, bus.ir_pc} !== {1'b1, exp}) begin n_fail++; $display("FAIL bp_head1: got v=%b ir=%h pc=%h expected v=1 ir=%h pc=%h", bus.ir_valid, bus.ir, bus.ir_pc, exp.instr, exp.pc); end
        wait_valid(got);
        exp = exp_q.pop_front();
        n_checks++; if (!got || {bus.ir, bus.ir_pc} !== exp) begin n_fail++; $display("FAIL bp_head2: got v=%b ir=%h pc=%h expected v=1 ir=%h pc=%h", got, bus.ir, bus.ir_pc, exp.instr, exp.pc); end
    endtask

    task automatic test_redirect_idle;
        bit got;
        apply_reset();
        mem_en = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++; if ({bus.ir_valid, bus.imem_req} !== 2'b10) begin n_fail++; $display("FAIL ri_setup: got valid=%b req=%b expected valid=1 req=0", bus.ir_valid, bus.imem_req); end
        mem_en = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        @(negedge clk);
        bus.redirect = 1'b0;
        n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL ri_flush: got %b expected 0", bus.ir_valid); end
        n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 6'h10}) begin n_fail++; $display("FAIL ri_addr: got req=%b addr=%h expected req=1 addr=10", bus.imem_req, bus.imem_addr); end
        exp_q.push_back('{instr: mem_word(6'h10), pc: 32'h40});
        mem_en = 1'b1;
        bus.ir_ready = 1'b1;
        wait_valid(got);
        exp = exp_q.pop_front();
        n_checks++; if (!got || {bus.ir, bus.ir_pc} !== exp) begin n_fail++; $display("FAIL ri_target: got v=%b ir=%h pc=%h expected v=1 ir=%h pc=%h", got, bus.ir, bus.ir_pc, exp.instr, exp.pc); end
    endtask

    task automatic test_redirect_busy;
        bit got;
        apply_reset();
        bus.ir_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rb_out: got %b expected 1", bus.imem_req); end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h80;
        @(negedge clk);
        bus.redirect = 1'b0;
        n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 6'h0}) begin n_fail++; $display("FAIL rb_hold1: got req=%b addr=%h expected req=1 addr=00", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 6'h0}) begin n_fail++; $display("FAIL rb_hold2: got req=%b addr=%h expected req=1 addr=00", bus.imem_req, bus.imem_addr); end
        man_ack = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        man_ack = 1'b0;
        n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rb_drop: got %b expected 0", bus.ir_valid); end
        n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 6'h20}) begin n_fail++; $display("FAIL rb_addr: got req=%b addr=%h expected req=1 addr=20", bus.imem_req, bus.imem_addr); end
        exp_q.push_back('{instr: mem_word(6'h20), pc: 32'h80});
        mem_en = 1'b1;
        wait_valid(got);
        exp = exp_q.pop_front();
        n_checks++; if (!got || {bus.ir, bus.ir_pc} !== exp) begin n_fail++; $display("FAIL rb_target: got v=%b ir=%h pc=%h expected v=1 ir=%h pc=%h", got, bus.ir, bus.ir_pc, exp.instr, exp.pc); end
    endtask

    task automatic test_redirect_ack_pop;
        bit got;
        apply_reset();
        @(negedge clk);
        man_ack = 1'b1;
        man_rdata = 32'h11;
        @(negedge clk);
        n_checks++; if ({bus.ir_valid, bus.imem_req, bus.imem_addr} !== {2'b11, 6'h1}) begin n_fail++; $display("FAIL rap_setup: got valid=%b req=%b addr=%h expected valid=1 req=1 addr=01", bus.ir_valid, bus.imem_req, bus.imem_addr); end
        man_rdata = 32'h5555_5555;
        bus.ir_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0013;
        @(negedge clk);
        man_ack = 1'b0;
        bus.ir_ready = 1'b0;
        bus.redirect = 1'b0;
        n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rap_empty: got %b expected 0", bus.ir_valid); end
        n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 6'h4}) begin n_fail++; $display("FAIL rap_addr: got req=%b addr=%h expected req=1 addr=04", bus.imem_req, bus.imem_addr); end
        exp_q.push_back('{instr: mem_word(6'h4), pc: 32'h10});
        mem_en = 1'b1;
        bus.ir_ready = 1'b1;
        wait_valid(got);
        exp = exp_q.pop_front();
        n_checks++; if (!got || {bus.ir, bus.ir_pc} !== exp) begin n_fail++; $display("FAIL rap_target: got v=%b ir=%h pc=%h expected v=1 ir=%h pc=%h", got, bus.ir, bus.ir_pc, exp.instr, exp.pc); end
    endtask

`ifdef INSTR_FETCH_PERF_EN
    task automatic test_perf;
        int pops;
        apply_reset();
        mem_en = 1'b1;
        pops = 0;
        for (int c = 0; c < 50 && pops < 3; c++) begin
            @(negedge clk);
            bus.ir_ready = 1'b1;
            if (bus.ir_valid) pops++;
        end
        @(negedge clk);
        bus.ir_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        @(negedge clk);
        bus.redirect = 1'b0;
        for (int c = 0; c < 50 && pops < 5; c++) begin
            @(negedge clk);
            bus.ir_ready = 1'b1;
            if (bus.ir_valid) pops++;
        end
        @(negedge clk);
        bus.ir_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (fetch_count !== 32'd5) begin n_fail++; $display("FAIL perf_count: got %0d expected 5", fetch_count); end
        mem_en = 1'b0;
        man_ack = 1'b0;
        bus.ir_ready = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL perf_outstanding: got %b expected 1", bus.imem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.imem_req, bus.ir_valid} !== 2'b00) begin n_fail++; $display("FAIL perf_async_req: got req=%b valid=%b expected 0 0", bus.imem_req, bus.ir_valid); end
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL perf_async_count: got %0d expected 0", fetch_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        bus.ir_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_idle();
        test_redirect_busy();
        test_redirect_ack_pop();
`ifdef INSTR_FETCH_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
